// File: rtl/run_controller.sv
// Run controller: sequences the core's active-low reset, counts RUN cycles,
// detects a halted core (PC unchanged for STALL_CYCLES samples), checks the
// result bus and reports pass / fail / timeout. All outputs are registered.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start, core held in reset
// RESET_HOLD | core held in reset for RESET_CYCLES edges after start
// RUN        | core released, counting cycles, watching pc for a halt
// DONE       | run finished, flags frozen, core held until next start
module run_controller #(
  parameter int                    RESET_CYCLES = 2,
  parameter int                    MAX_CYCLES   = 33,
  parameter int                    STALL_CYCLES = 4,
  parameter int                    PC_WIDTH     = 8,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] EXPECT_VALUE = 8'h2A,
  parameter bit                    CHECK_EN     = 1'b1,
  localparam int                   CNT_W        = $clog2(MAX_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  cpu_nReset,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t               state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 pc_valid;

  logic pc_same;
  logic halt;
  logic budget_out;
  logic result_ok;

  // Halt and budget decisions for the current RUN edge.
  always_comb begin
    pc_same    = (pc == pc_q);
    halt       = pc_valid && pc_same && (stall_cnt == STALL_LAST);
    budget_out = (cycle_count == CNT_LAST);
    result_ok  = !CHECK_EN || (result == EXPECT_VALUE);
  end

  // Sequencer FSM with registered outputs; reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_nReset  <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      hold_cnt    <= '0;
      stall_cnt   <= '0;
      pc_q        <= '0;
      pc_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RESET_HOLD;
            cpu_nReset  <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            pc_valid    <= 1'b0;
          end
        end

        RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            cpu_nReset <= 1'b1;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          pc_q        <= pc;
          pc_valid    <= 1'b1;
          if (pc_valid) begin
            stall_cnt <= pc_same ? stall_cnt + STALL_W'(1) : '0;
          end
          if (halt) begin
            state      <= DONE;
            cpu_nReset <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
            pass       <= result_ok;
            timeout    <= 1'b0;
          end else if (budget_out) begin
            state      <= DONE;
            cpu_nReset <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
